// File: rtl/idli_fetch_m.sv
// Instruction fetch front end: issues a sequential SQI READ from the current
// PC and streams the returned nibbles to decode, MSB nibble first. A redirect
// from execute, or running off the top of the address space, restarts the read.
module idli_fetch_m #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [7:0]  READ_CMD     = 8'h03,
    parameter int unsigned DUMMY_CYCLES = 2
) (
    input  logic        i_fetch_gck,
    input  logic        i_fetch_rst_n,
    output logic        o_fetch_sqi_cs_n,
    output logic        o_fetch_sqi_oe,
    output logic [3:0]  o_fetch_sqi_dout,
    input  logic [3:0]  i_fetch_sqi_din,
    output logic [3:0]  o_fetch_enc,
    output logic        o_fetch_enc_vld,
    output logic [15:0] o_fetch_pc,
    input  logic        i_fetch_redirect,
    input  logic [15:0] i_fetch_redirect_pc
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4
    } state_t;

    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [23:0] byte_addr;
    logic [3:0]  addr_nibble;

    // The memory is byte addressed; instruction words sit at even byte addresses.
    assign byte_addr  = {7'b0, pc_q, 1'b0};
    assign o_fetch_pc = pc_q;

    // State, counter and PC registers; reset drops any transaction in flight.
    always_ff @(posedge i_fetch_gck or negedge i_fetch_rst_n) begin
        if (!i_fetch_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state sequencing: CMD -> ADDR -> DUMMY -> DATA, with redirect overriding all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                state_d = CMD;
                cnt_d   = 3'd0;
            end
            CMD: begin
                if (cnt_q == 3'd1) begin
                    state_d = ADDR;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ADDR: begin
                if (cnt_q == 3'd5) begin
                    state_d = DUMMY;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DUMMY: begin
                if (cnt_q == DUMMY_LAST) begin
                    state_d = DATA;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DATA: begin
                if (cnt_q == 3'd3) begin
                    cnt_d = 3'd0;
                    pc_d  = pc_q + 16'd1;
                    if (pc_q == 16'hFFFF) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        if (i_fetch_redirect) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            pc_d    = i_fetch_redirect_pc;
        end
    end

    // Select the address nibble for this ADDR cycle, most significant first.
    always_comb begin
        addr_nibble = 4'h0;
        case (cnt_q)
            3'd0:    addr_nibble = byte_addr[23:20];
            3'd1:    addr_nibble = byte_addr[19:16];
            3'd2:    addr_nibble = byte_addr[15:12];
            3'd3:    addr_nibble = byte_addr[11:8];
            3'd4:    addr_nibble = byte_addr[7:4];
            3'd5:    addr_nibble = byte_addr[3:0];
            default: addr_nibble = 4'h0;
        endcase
    end

    // SQI pin and decode outputs; oe is only raised while we own the bus.
    always_comb begin
        o_fetch_sqi_cs_n = 1'b1;
        o_fetch_sqi_oe   = 1'b0;
        o_fetch_sqi_dout = 4'h0;
        o_fetch_enc      = 4'h0;
        o_fetch_enc_vld  = 1'b0;
        case (state_q)
            CMD: begin
                o_fetch_sqi_cs_n = 1'b0;
                o_fetch_sqi_oe   = 1'b1;
                o_fetch_sqi_dout = cnt_q[0] ? READ_CMD[3:0] : READ_CMD[7:4];
            end
            ADDR: begin
                o_fetch_sqi_cs_n = 1'b0;
                o_fetch_sqi_oe   = 1'b1;
                o_fetch_sqi_dout = addr_nibble;
            end
            DUMMY: begin
                o_fetch_sqi_cs_n = 1'b0;
            end
            DATA: begin
                o_fetch_sqi_cs_n = 1'b0;
                o_fetch_enc      = i_fetch_sqi_din;
                o_fetch_enc_vld  = ~i_fetch_redirect;
            end
            default: begin
                o_fetch_sqi_cs_n = 1'b1;
            end
        endcase
    end

endmodule
